// File: rtl/ship_controller.sv
// ship_controller: player gun position, lives state machine and per-pixel ship colour code.
// Latency: color is registered one cycle after hPos/vPos; gun/lives/state update on the triggering edge.
// Backpressure: none, free-running pixel stream; optional SHIP_CONTROLLER_BLINK_EN blinks the ship in RESPAWN.
module ship_controller #(
  parameter int SCREEN_WIDTH   = 640,
  parameter int SCREEN_HEIGHT  = 480,
  parameter int SHIP_WIDTH     = 60,
  parameter int SHIP_HEIGHT    = 30,
  parameter int STEP           = 20,
  parameter int H_OFFSET       = 10,
  parameter int V_OFFSET       = 10,
  parameter int RECT_PERCENT   = 15,
  parameter int LIVES          = 3,
  parameter int EXPLODE_FRAMES = 30,
  parameter int INVULN_FRAMES  = 60,
  parameter int COLOR_EXPLODE  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frameTick,
  input  logic       left,
  input  logic       right,
  input  logic       hit,
  input  logic       start,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  output logic [9:0] gunPosition,
  output logic [2:0] color,
  output logic [2:0] lives,
  output logic       alive,
  output logic       gameOver
);

  // Geometry derived from the parameters; all position maths is 11 bits wide
  // so that adding STEP or half a ship never wraps.
  localparam int RW     = SHIP_WIDTH * RECT_PERCENT / 100;
  localparam int HALF_W = SHIP_WIDTH / 2;
  localparam int TOP    = SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT;
  localparam int XMIN   = H_OFFSET + HALF_W;
  localparam int XMAX   = SCREEN_WIDTH - H_OFFSET - HALF_W;
  localparam int CENTER = SCREEN_WIDTH / 2;

  localparam logic [10:0] RW_W       = 11'(RW);
  localparam logic [10:0] RRECT_W    = 11'(SHIP_WIDTH - RW);
  localparam logic [10:0] HALF_W_W   = 11'(HALF_W);
  localparam logic [10:0] TOP_W      = 11'(TOP);
  localparam logic [10:0] BOTTOM_W   = 11'(TOP + SHIP_HEIGHT);
  localparam logic [10:0] LAST_ROW_W = 11'(SHIP_HEIGHT - 1);
  localparam logic [10:0] XMIN_W     = 11'(XMIN);
  localparam logic [10:0] XMAX_W     = 11'(XMAX);
  localparam logic [10:0] STEP_W     = 11'(STEP);
  localparam logic [9:0]  CENTER_W   = 10'(CENTER);
  localparam logic [2:0]  LIVES_W    = 3'(LIVES);
  localparam logic [7:0]  EXPLODE_LAST = 8'(EXPLODE_FRAMES - 1);
  localparam logic [7:0]  INVULN_LAST  = 8'(INVULN_FRAMES - 1);

  localparam logic [2:0] C_SHIP    = 3'd1;
  localparam logic [2:0] C_EXPLODE = 3'(COLOR_EXPLODE);
  localparam logic [2:0] C_NONE    = 3'd7;

  typedef enum logic [1:0] {
    ST_ALIVE     = 2'd0,
    ST_EXPLODING = 2'd1,
    ST_RESPAWN   = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  frame_cnt;

  logic [10:0] gun_ext;
  logic [10:0] right_sum;
  logic [10:0] right_pos;
  logic [10:0] left_pos;
  logic [10:0] moved_pos;
  logic        explode_done;
  logic        invuln_done;

  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic [10:0] box_left;
  logic [10:0] box_right;
  logic [10:0] x_off;
  logic [10:0] d_row;
  logic [10:0] h_dist;
  logic        in_box;
  logic        ship_px;
  logic        explode_px;
  logic        draw_ship;
  logic [2:0]  pix_color;

  assign alive    = (state == ST_ALIVE) || (state == ST_RESPAWN);
  assign gameOver = (state == ST_GAME_OVER);

  assign explode_done = frameTick && (frame_cnt == EXPLODE_LAST);
  assign invuln_done  = frameTick && (frame_cnt == INVULN_LAST);

  // Candidate gun position for this frame: clamp to the playfield, no move
  // when both directions are requested at once.
  always_comb begin
    gun_ext   = {1'b0, gunPosition};
    right_sum = gun_ext + STEP_W;
    right_pos = (right_sum > XMAX_W) ? XMAX_W : right_sum;
    // Compare before subtracting so a small position can never underflow.
    left_pos  = (gun_ext >= XMIN_W + STEP_W) ? (gun_ext - STEP_W) : XMIN_W;
    moved_pos = gun_ext;
    if (right && !left) begin
      moved_pos = right_pos;
    end else if (left && !right) begin
      moved_pos = left_pos;
    end
  end

  // Lives / explode / respawn / game-over state machine with the gun register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_ALIVE;
      frame_cnt   <= 8'd0;
      gunPosition <= CENTER_W;
      lives       <= LIVES_W;
    end else begin
      case (state)
        ST_ALIVE: begin
          // A hit wins over a same-cycle frame tick; the move is dropped.
          if (hit) begin
            lives     <= lives - 3'd1;
            state     <= ST_EXPLODING;
            frame_cnt <= 8'd0;
          end else if (frameTick) begin
            gunPosition <= 10'(moved_pos);
            frame_cnt   <= frame_cnt + 8'd1;
          end
        end
        ST_EXPLODING: begin
          if (explode_done) begin
            frame_cnt <= 8'd0;
            if (lives == 3'd0) begin
              state <= ST_GAME_OVER;
            end else begin
              state       <= ST_RESPAWN;
              gunPosition <= CENTER_W;
            end
          end else if (frameTick) begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        ST_RESPAWN: begin
          // Invulnerable: hit is ignored, but the player can still steer.
          if (frameTick) begin
            gunPosition <= 10'(moved_pos);
            if (invuln_done) begin
              state     <= ST_ALIVE;
              frame_cnt <= 8'd0;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        default: begin
          if (start) begin
            lives       <= LIVES_W;
            gunPosition <= CENTER_W;
            state       <= ST_RESPAWN;
            frame_cnt   <= 8'd0;
          end else if (frameTick) begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  // Ship shape: two side rectangles, a solid bottom row and a widening
  // wedge from the centre column, all inside the ship bounding box.
  always_comb begin
    h_ext      = {1'b0, hPos};
    v_ext      = {1'b0, vPos};
    box_left   = {1'b0, gunPosition} - HALF_W_W;
    box_right  = {1'b0, gunPosition} + HALF_W_W;
    in_box     = (h_ext >= box_left) && (h_ext < box_right) &&
                 (v_ext >= TOP_W) && (v_ext < BOTTOM_W);
    x_off      = h_ext - box_left;
    d_row      = v_ext - TOP_W;
    h_dist     = (hPos >= gunPosition) ? (h_ext - {1'b0, gunPosition})
                                       : ({1'b0, gunPosition} - h_ext);
    ship_px    = in_box && ((x_off < RW_W) || (x_off >= RRECT_W) ||
                            (d_row == LAST_ROW_W) || (h_dist < d_row));
    explode_px = in_box && (hPos[2] ^ vPos[2] ^ frame_cnt[0]);
  end

  // Per-state colour selection, before the output register.
  always_comb begin
    pix_color = C_NONE;
`ifdef SHIP_CONTROLLER_BLINK_EN
    draw_ship = ship_px && !frame_cnt[2];
`else
    draw_ship = ship_px;
`endif
    case (state)
      ST_ALIVE:     pix_color = ship_px ? C_SHIP : C_NONE;
      ST_RESPAWN:   pix_color = draw_ship ? C_SHIP : C_NONE;
      ST_EXPLODING: pix_color = explode_px ? C_EXPLODE : C_NONE;
      default:      pix_color = C_NONE;
    endcase
  end

  // Colour register: one pixel of latency toward the mixer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      color <= C_NONE;
    end else begin
      color <= pix_color;
    end
  end

endmodule

// File: tb/tb_ship_controller.sv
// tb_ship_controller: directed vector table plus hand sequences for ship_controller.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: none; every wait is a fixed number of cycles.
module tb_ship_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frameTick = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       hit = 1'b0;
  logic       start = 1'b0;
  logic [9:0] hPos = 10'd0;
  logic [9:0] vPos = 10'd0;
  logic [9:0] gunPosition;
  logic [2:0] color;
  logic [2:0] lives;
  logic       alive;
  logic       gameOver;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SHIP_CONTROLLER_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  ship_controller dut (
    .clk        (clk),
    .reset      (reset),
    .frameTick  (frameTick),
    .left       (left),
    .right      (right),
    .hit        (hit),
    .start      (start),
    .hPos       (hPos),
    .vPos       (vPos),
    .gunPosition(gunPosition),
    .color      (color),
    .lives      (lives),
    .alive      (alive),
    .gameOver   (gameOver)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ft;
    logic l;
    logic r;
    int   h;
    int   v;
    int   exp_gun;
    int   exp_col;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic l, input logic r);
    frameTick = 1'b1;
    left = l;
    right = r;
    cyc();
    frameTick = 1'b0;
    left = 1'b0;
    right = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    cyc();
    hit = 1'b0;
  endtask

  task automatic pix(input int h, input int v);
    hPos = 10'(h);
    vPos = 10'(v);
  endtask

  initial begin
    // Geometry at defaults: TOP=440, box = gun-30 .. gun+29, RW=9, XMIN=40, XMAX=600.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 292, 445, 320, 1};  // left rectangle
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 320, 440, 320, 7};  // wedge apex row, d=0
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 320, 450, 320, 1};  // wedge centre
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 300, 469, 320, 1};  // bottom row
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 320, 470, 320, 7};  // below box
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 330, 441, 320, 7};  // inside box, outside wedge
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 349, 460, 320, 1};  // right rectangle last column
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 350, 460, 320, 7};  // just right of box
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 289, 460, 320, 7};  // just left of box
    tbl[9]  = '{1'b0, 1'b0, 1'b1,   0,   0, 320, 7};  // right without tick
    tbl[10] = '{1'b1, 1'b1, 1'b1,   0,   0, 320, 7};  // both directions
    tbl[11] = '{1'b1, 1'b0, 1'b1, 292, 445, 340, 1};  // colour uses pre-move gun
    tbl[12] = '{1'b1, 1'b0, 1'b1,   0,   0, 360, 7};
    tbl[13] = '{1'b1, 1'b0, 1'b1,   0,   0, 380, 7};
    tbl[14] = '{1'b1, 1'b0, 1'b1,   0,   0, 400, 7};
    tbl[15] = '{1'b1, 1'b0, 1'b1,   0,   0, 420, 7};

    // Reset, with a ship pixel on the bus so the colour reset is visible.
    reset = 1'b0;
    pix(292, 445);
    cyc();
    cyc();
    chk("reset_gun", 32'(gunPosition), 320);
    chk("reset_color", 32'(color), 7);
    chk("reset_lives", 32'(lives), 3);
    chk("reset_alive", 32'(alive), 1);
    chk("reset_gameover", 32'(gameOver), 0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      frameTick = tbl[i].ft;
      left = tbl[i].l;
      right = tbl[i].r;
      pix(tbl[i].h, tbl[i].v);
      cyc();
      chk($sformatf("vec%0d_gun", i), 32'(gunPosition), 32'(tbl[i].exp_gun));
      chk($sformatf("vec%0d_color", i), 32'(color), 32'(tbl[i].exp_col));
    end
    frameTick = 1'b0;
    left = 1'b0;
    right = 1'b0;
    pix(0, 0);
    chk("vec_lives", 32'(lives), 3);

    // Clamp at the right edge.
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b1);
    chk("right_reach", 32'(gunPosition), 600);
    tick(1'b0, 1'b1);
    chk("right_clamp", 32'(gunPosition), 600);

    // Walk left to 60, then onto and against the left limit.
    for (int i = 0; i < 27; i++) tick(1'b1, 1'b0);
    chk("left_walk", 32'(gunPosition), 60);
    tick(1'b1, 1'b0);
    chk("left_reach", 32'(gunPosition), 40);
    tick(1'b1, 1'b0);
    chk("left_clamp", 32'(gunPosition), 40);

    // Hit in ALIVE at gun=40 (box 10..69).
    pix(12, 440);
    pulse_hit();
    chk("hit_lives", 32'(lives), 2);
    chk("hit_alive", 32'(alive), 0);
    cyc();
    chk("explode_px_on", 32'(color), 6);      // 12[2]=1, 440[2]=0, cnt[0]=0
    pix(16, 440);
    cyc();
    chk("explode_px_off", 32'(color), 7);     // 16[2]=0
    tick(1'b0, 1'b1);
    chk("explode_pre_tick", 32'(color), 7);   // counter still 0 when sampled
    chk("explode_no_move", 32'(gunPosition), 40);
    cyc();
    chk("explode_px_toggle", 32'(color), 6);  // counter now 1
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_ignored_lives", 32'(lives), 2);
    chk("start_ignored_alive", 32'(alive), 0);
    ticks(28);
    chk("explode_last_frame", 32'(alive), 0);
    tick(1'b0, 1'b0);
    chk("respawn_alive", 32'(alive), 1);
    chk("respawn_gun", 32'(gunPosition), 320);

    // RESPAWN blink pattern over frames 0..7.
    pix(320, 450);
    for (int f = 0; f < 8; f++) begin
      cyc();
      chk($sformatf("respawn_f%0d_color", f), 32'(color),
          (BLINK && f >= 4) ? 32'd7 : 32'd1);
      tick(1'b0, 1'b0);
    end
    pulse_hit();
    chk("respawn_hit_ignored", 32'(lives), 2);
    chk("respawn_hit_alive", 32'(alive), 1);
    ticks(51);
    pulse_hit();
    chk("respawn_last_hit_ignored", 32'(lives), 2);
    tick(1'b0, 1'b0);
    pulse_hit();
    chk("alive_again_hit", 32'(lives), 1);
    chk("alive_again_hit_alive", 32'(alive), 0);

    // Second full cycle, then the final hit coinciding with a move tick.
    ticks(30);
    chk("second_respawn", 32'(alive), 1);
    ticks(60);
    hit = 1'b1;
    frameTick = 1'b1;
    right = 1'b1;
    cyc();
    hit = 1'b0;
    frameTick = 1'b0;
    right = 1'b0;
    chk("hit_tick_lives", 32'(lives), 0);
    chk("hit_tick_no_move", 32'(gunPosition), 320);
    ticks(29);
    chk("pre_gameover", 32'(gameOver), 0);
    tick(1'b0, 1'b0);
    chk("gameover_flag", 32'(gameOver), 1);
    chk("gameover_alive", 32'(alive), 0);
    chk("gameover_lives", 32'(lives), 0);

    // GAME_OVER: blank, frozen, deaf to hit.
    pix(320, 450);
    cyc();
    cyc();
    chk("gameover_color", 32'(color), 7);
    tick(1'b0, 1'b1);
    chk("gameover_no_move", 32'(gunPosition), 320);
    pulse_hit();
    chk("gameover_hit_ignored", 32'(gameOver), 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_lives", 32'(lives), 3);
    chk("restart_alive", 32'(alive), 1);
    chk("restart_gameover", 32'(gameOver), 0);

    // Reset in the middle of RESPAWN.
    tick(1'b0, 1'b1);
    chk("restart_move", 32'(gunPosition), 340);
    ticks(2);
    pix(312, 445);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("mid_respawn_reset_gun", 32'(gunPosition), 320);
    chk("mid_respawn_reset_color", 32'(color), 7);
    chk("mid_respawn_reset_lives", 32'(lives), 3);
    pulse_hit();
    chk("after_reset_is_alive", 32'(lives), 2);

    // Reset in the middle of EXPLODING.
    ticks(5);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("mid_explode_reset_lives", 32'(lives), 3);
    chk("mid_explode_reset_alive", 32'(alive), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
